// File: rtl/rob_commit.sv
// -----------------------------------------------------------------------------
// rob_commit
// Reorder buffer and commit stage. Dispatch allocates entries in order, the INT
// and LS units write results back out of order, and completed entries at the
// head retire in program order onto the register-file write ports.
//
// Ports
//   clk, res                       clock / asynchronous active-high reset
//   alloc_*_dec2rob / rob2dec      in-order allocation handshake, granted tag
//   wb_*_int2rob, wb_*_ls2rob      out-of-order result writeback by tag
//   write_select/en_0, value_0     commit port 0 (older entry), registered
//   write_select/en_1, value_1     commit port 1 (younger entry), registered
//   count_rob2dec                  number of occupied entries
//
// Configuration macro: COMMIT_DUAL_EN
//   defined   : up to two head entries retire per cycle
//   undefined : one entry retires per cycle, port 1 outputs tied to zero
// -----------------------------------------------------------------------------
module rob_commit #(
  parameter int  DEPTH   = 16,
  parameter int  XLEN    = 64,
  parameter int  RADDR_W = 6,
  localparam int TW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               res,
  input  logic               alloc_valid_dec2rob,
  input  logic [RADDR_W-1:0] alloc_rd_dec2rob,
  input  logic               alloc_wb_dec2rob,
  output logic               alloc_ready_rob2dec,
  output logic [TW-1:0]      alloc_tag_rob2dec,
  input  logic               wb_valid_int2rob,
  input  logic [TW-1:0]      wb_tag_int2rob,
  input  logic [XLEN-1:0]    wb_value_int2rob,
  input  logic               wb_valid_ls2rob,
  input  logic [TW-1:0]      wb_tag_ls2rob,
  input  logic [XLEN-1:0]    wb_value_ls2rob,
  output logic [RADDR_W-1:0] write_select_0_rob2rf,
  output logic               write_en_0_rob2rf,
  output logic [XLEN-1:0]    value_0_rob2rf,
  output logic [RADDR_W-1:0] write_select_1_rob2rf,
  output logic               write_en_1_rob2rf,
  output logic [XLEN-1:0]    value_1_rob2rf,
  output logic [TW:0]        count_rob2dec
);

  localparam logic [TW:0]   FULL_CNT = (TW+1)'(DEPTH);
  localparam logic [TW:0]   PTR_ONE  = (TW+1)'(1);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TW:0]                   head_q, head_d;
  logic [TW:0]                   tail_q, tail_d;
  logic [DEPTH-1:0]              busy_q, busy_d;
  logic [DEPTH-1:0]              done_q, done_d;
  logic [DEPTH-1:0]              wbf_q, wbf_d;
  logic [DEPTH-1:0][RADDR_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][XLEN-1:0]    val_q, val_d;

  logic [RADDR_W-1:0]            sel0_q, sel0_d;
  logic                          en0_q, en0_d;
  logic [XLEN-1:0]               out0_q, out0_d;
`ifdef COMMIT_DUAL_EN
  logic [RADDR_W-1:0]            sel1_q, sel1_d;
  logic                          en1_q, en1_d;
  logic [XLEN-1:0]               out1_q, out1_d;
  logic [TW-1:0]                 head1_s;
`endif

  logic [TW:0]                   count_s;
  logic [TW-1:0]                 head0_s;
  logic [TW-1:0]                 tail_idx_s;
  logic                          alloc_fire_s;
  logic                          c0_s;
  logic                          c1_s;

  assign count_s             = tail_q - head_q;
  assign head0_s             = head_q[TW-1:0];
  assign tail_idx_s          = tail_q[TW-1:0];
  // Space is judged on the registered count only, so a same-cycle commit
  // never frees room for this cycle's allocation.
  assign alloc_ready_rob2dec = (count_s < FULL_CNT);
  assign alloc_tag_rob2dec   = tail_idx_s;
  assign alloc_fire_s        = alloc_valid_dec2rob & alloc_ready_rob2dec;
  assign count_rob2dec       = count_s;

  assign write_select_0_rob2rf = sel0_q;
  assign write_en_0_rob2rf     = en0_q;
  assign value_0_rob2rf        = out0_q;
`ifdef COMMIT_DUAL_EN
  assign head1_s               = head0_s + TW'(1);
  assign write_select_1_rob2rf = sel1_q;
  assign write_en_1_rob2rf     = en1_q;
  assign value_1_rob2rf        = out1_q;
`else
  assign write_select_1_rob2rf = {RADDR_W{1'b0}};
  assign write_en_1_rob2rf     = 1'b0;
  assign value_1_rob2rf        = {XLEN{1'b0}};
`endif

  // Commit eligibility of the oldest one or two entries, from registered state.
  always_comb begin
    c0_s = busy_q[head0_s] & done_q[head0_s];
`ifdef COMMIT_DUAL_EN
    c1_s = c0_s & busy_q[head1_s] & done_q[head1_s];
`else
    c1_s = 1'b0;
`endif
  end

  // Next-state: writeback, allocation, commit and commit-port registers.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    busy_d = busy_q;
    done_d = done_q;
    wbf_d  = wbf_q;
    rd_d   = rd_q;
    val_d  = val_q;
    sel0_d = sel0_q;
    en0_d  = 1'b0;
    out0_d = out0_q;
`ifdef COMMIT_DUAL_EN
    sel1_d = sel1_q;
    en1_d  = 1'b0;
    out1_d = out1_q;
`endif

    // Writeback only lands on occupied entries; INT has priority over LS.
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_valid_int2rob && busy_q[i] && (wb_tag_int2rob == TW'(i))) begin
        done_d[i] = 1'b1;
        val_d[i]  = wb_value_int2rob;
      end else if (wb_valid_ls2rob && busy_q[i] && (wb_tag_ls2rob == TW'(i))) begin
        done_d[i] = 1'b1;
        val_d[i]  = wb_value_ls2rob;
      end else begin
        done_d[i] = done_q[i];
        val_d[i]  = val_q[i];
      end
    end

    // The tail slot is never busy, so this cannot collide with writeback.
    if (alloc_fire_s) begin
      busy_d[tail_idx_s] = 1'b1;
      done_d[tail_idx_s] = 1'b0;
      rd_d[tail_idx_s]   = alloc_rd_dec2rob;
      wbf_d[tail_idx_s]  = alloc_wb_dec2rob;
      tail_d             = tail_q + PTR_ONE;
    end else begin
      tail_d             = tail_q;
    end

    if (c0_s) begin
      busy_d[head0_s] = 1'b0;
      sel0_d          = rd_q[head0_s];
      out0_d          = val_q[head0_s];
      en0_d           = wbf_q[head0_s];
    end else begin
      sel0_d          = sel0_q;
      out0_d          = out0_q;
      en0_d           = 1'b0;
    end

`ifdef COMMIT_DUAL_EN
    if (c1_s) begin
      busy_d[head1_s] = 1'b0;
      sel1_d          = rd_q[head1_s];
      out1_d          = val_q[head1_s];
      en1_d           = wbf_q[head1_s];
    end else begin
      sel1_d          = sel1_q;
      out1_d          = out1_q;
      en1_d           = 1'b0;
    end
`endif

    head_d = head_q + {{TW{1'b0}}, c0_s} + {{TW{1'b0}}, c1_s};
  end

  // State registers; reset discards every entry and clears the commit ports.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      head_q <= '0;
      tail_q <= '0;
      busy_q <= '0;
      done_q <= '0;
      wbf_q  <= '0;
      rd_q   <= '0;
      val_q  <= '0;
      sel0_q <= '0;
      en0_q  <= 1'b0;
      out0_q <= '0;
`ifdef COMMIT_DUAL_EN
      sel1_q <= '0;
      en1_q  <= 1'b0;
      out1_q <= '0;
`endif
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wbf_q  <= wbf_d;
      rd_q   <= rd_d;
      val_q  <= val_d;
      sel0_q <= sel0_d;
      en0_q  <= en0_d;
      out0_q <= out0_d;
`ifdef COMMIT_DUAL_EN
      sel1_q <= sel1_d;
      en1_q  <= en1_d;
      out1_q <= out1_d;
`endif
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// -----------------------------------------------------------------------------
// tb_rob_commit
// Self-checking bench for rob_commit. A program-order queue of in-flight
// instructions serves as the reference; every cycle the DUT's count, grant and
// commit ports are compared against it. Directed sequences cover the basic
// commit, out-of-order completion, full/wrap, no-write entries, INT/LS tag
// collision and mid-stream reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_rob_commit;

  localparam int DEPTH = 16;
`ifdef COMMIT_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [5:0]  alloc_rd = 6'd0;
  logic        alloc_wb = 1'b0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        int_valid = 1'b0;
  logic [3:0]  int_tag = 4'd0;
  logic [63:0] int_value = 64'd0;
  logic        ls_valid = 1'b0;
  logic [3:0]  ls_tag = 4'd0;
  logic [63:0] ls_value = 64'd0;
  logic [5:0]  sel0, sel1;
  logic        en0, en1;
  logic [63:0] val0, val1;
  logic [4:0]  count;

  rob_commit dut (
    .clk                   (clk),
    .res                   (res),
    .alloc_valid_dec2rob   (alloc_valid),
    .alloc_rd_dec2rob      (alloc_rd),
    .alloc_wb_dec2rob      (alloc_wb),
    .alloc_ready_rob2dec   (alloc_ready),
    .alloc_tag_rob2dec     (alloc_tag),
    .wb_valid_int2rob      (int_valid),
    .wb_tag_int2rob        (int_tag),
    .wb_value_int2rob      (int_value),
    .wb_valid_ls2rob       (ls_valid),
    .wb_tag_ls2rob         (ls_tag),
    .wb_value_ls2rob       (ls_value),
    .write_select_0_rob2rf (sel0),
    .write_en_0_rob2rf     (en0),
    .value_0_rob2rf        (val0),
    .write_select_1_rob2rf (sel1),
    .write_en_1_rob2rf     (en1),
    .value_1_rob2rf        (val1),
    .count_rob2dec         (count)
  );

  always #5 clk = ~clk;

  // Reference: in-flight instructions, oldest first.
  typedef struct {
    int          tag;
    logic [5:0]  rd;
    logic        wb;
    logic        done;
    logic [63:0] value;
  } ent_t;

  ent_t        rob[$];
  int          m_tail;
  logic [5:0]  m_sel0, m_sel1;
  logic        m_en0, m_en1;
  logic [63:0] m_val0, m_val1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rob.delete();
    m_tail = 0;
    m_sel0 = 6'd0; m_sel1 = 6'd0;
    m_en0  = 1'b0; m_en1  = 1'b0;
    m_val0 = 64'd0; m_val1 = 64'd0;
  endtask

  // One clock of the reference, using the state before the edge.
  task automatic model_step();
    int  ncommit;
    bit  rdy;
    rdy     = (rob.size() < DEPTH);
    ncommit = 0;
    m_en0   = 1'b0;
    m_en1   = 1'b0;
    if (rob.size() > 0 && rob[0].done) begin
      ncommit = 1;
      m_sel0  = rob[0].rd;
      m_val0  = rob[0].value;
      m_en0   = rob[0].wb;
      if (DUAL && rob.size() > 1 && rob[1].done) begin
        ncommit = 2;
        m_sel1  = rob[1].rd;
        m_val1  = rob[1].value;
        m_en1   = rob[1].wb;
      end
    end
    // LS applied first so INT overrides it on a shared tag.
    foreach (rob[i]) begin
      if (ls_valid && rob[i].tag == int'(ls_tag)) begin
        rob[i].done = 1'b1; rob[i].value = ls_value;
      end
      if (int_valid && rob[i].tag == int'(int_tag)) begin
        rob[i].done = 1'b1; rob[i].value = int_value;
      end
    end
    for (int k = 0; k < ncommit; k++) void'(rob.pop_front());
    if (alloc_valid && rdy) begin
      rob.push_back('{tag: m_tail, rd: alloc_rd, wb: alloc_wb, done: 1'b0, value: 64'd0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic check_outputs();
    chk_eq("count",       64'(count),       64'(rob.size()));
    chk_eq("alloc_ready", 64'(alloc_ready), 64'(rob.size() < DEPTH));
    chk_eq("alloc_tag",   64'(alloc_tag),   64'(m_tail));
    chk_eq("write_en_0",  64'(en0),  64'(m_en0));
    chk_eq("select_0",    64'(sel0), 64'(m_sel0));
    chk_eq("value_0",     val0,      m_val0);
    chk_eq("write_en_1",  64'(en1),  64'(m_en1));
    chk_eq("select_1",    64'(sel1), 64'(m_sel1));
    chk_eq("value_1",     val1,      m_val1);
  endtask

  // Called at a negedge: drive inputs, clock once, update reference, check.
  task automatic step(input logic av, input logic [5:0] ard, input logic awb,
                      input logic iv, input logic [3:0] itag, input logic [63:0] ival,
                      input logic lv, input logic [3:0] ltag, input logic [63:0] lval);
    alloc_valid = av;  alloc_rd = ard;  alloc_wb = awb;
    int_valid   = iv;  int_tag  = itag; int_value = ival;
    ls_valid    = lv;  ls_tag   = ltag; ls_value  = lval;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0);
  endtask

  task automatic alloc(input logic [5:0] rd, input logic wb);
    step(1'b1, rd, wb, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0);
  endtask

  task automatic wb_int(input int tag, input logic [63:0] v);
    step(1'b0, 6'd0, 1'b0, 1'b1, 4'(tag), v, 1'b0, 4'd0, 64'd0);
  endtask

  // Complete everything outstanding and let it retire, bounded.
  task automatic drain();
    int pend[$];
    for (int c = 0; c < 64 && rob.size() > 0; c++) begin
      pend = {};
      foreach (rob[i]) if (!rob[i].done) pend.push_back(rob[i].tag);
      if (pend.size() >= 2)
        step(1'b0, 6'd0, 1'b0, 1'b1, 4'(pend[0]), {$urandom, $urandom},
             1'b1, 4'(pend[1]), {$urandom, $urandom});
      else if (pend.size() == 1)
        wb_int(pend[0], {$urandom, $urandom});
      else
        idle();
    end
    chk_eq("drain_empty", 64'(count), 64'd0);
  endtask

  int          cand[$];
  int          it, lt, pct_alloc, pct_wb;
  logic        av, iv, lv;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_eq("rst_ready", 64'(alloc_ready), 64'd1);
    chk_eq("rst_tag",   64'(alloc_tag),   64'd0);
    chk_eq("rst_count", 64'(count),       64'd0);
    chk_eq("rst_en0",   64'(en0),         64'd0);
    chk_eq("rst_en1",   64'(en1),         64'd0);
    chk_eq("rst_val0",  val0 | val1 | 64'({sel0, sel1}), 64'd0);
    res = 1'b0;

    // Single entry, single writeback.
    alloc(6'd5, 1'b1);
    wb_int(0, 64'hDEAD);
    idle();
    chk_eq("basic_en0",   64'(en0),   64'd1);
    chk_eq("basic_sel0",  64'(sel0),  64'd5);
    chk_eq("basic_val0",  val0,       64'hDEAD);
    chk_eq("basic_count", 64'(count), 64'd0);

    // Younger completes first; nothing retires until the older one is done.
    alloc(6'd3, 1'b1);
    alloc(6'd4, 1'b1);
    step(1'b0, 6'd0, 1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd2, 64'h22);
    wb_int(1, 64'h11);
    chk_eq("ooo_hold_en0", 64'(en0), 64'd0);
    idle();
    chk_eq("ooo_sel0", 64'(sel0), 64'd3);
    chk_eq("ooo_val0", val0,      64'h11);
`ifdef COMMIT_DUAL_EN
    chk_eq("ooo_en1",  64'(en1),  64'd1);
    chk_eq("ooo_sel1", 64'(sel1), 64'd4);
    chk_eq("ooo_val1", val1,      64'h22);
`else
    idle();
    chk_eq("ooo_en0_2nd",  64'(en0),  64'd1);
    chk_eq("ooo_sel0_2nd", 64'(sel0), 64'd4);
    chk_eq("ooo_val0_2nd", val0,      64'h22);
`endif
    idle();

    // Fill to capacity, attempt one more, then free a single slot.
    for (int k = 0; k < DEPTH; k++) alloc(6'(k + 10), 1'b1);
    chk_eq("full_count", 64'(count),       64'd16);
    chk_eq("full_ready", 64'(alloc_ready), 64'd0);
    alloc(6'd63, 1'b1);
    chk_eq("full_ignored", 64'(count), 64'd16);
    wb_int(rob[0].tag, 64'h5A5A);
    idle();
    chk_eq("freed_ready", 64'(alloc_ready), 64'd1);
    alloc(6'd7, 1'b1);
    drain();

    // Entry without register write, then an INT/LS collision on one tag.
    alloc(6'd9, 1'b0);
    wb_int(m_tail == 0 ? DEPTH - 1 : m_tail - 1, 64'h77);
    idle();
    chk_eq("nowb_en0",   64'(en0),   64'd0);
    chk_eq("nowb_count", 64'(count), 64'd0);
    alloc(6'd10, 1'b1);
    it = (m_tail == 0) ? DEPTH - 1 : m_tail - 1;
    step(1'b0, 6'd0, 1'b0, 1'b1, 4'(it), 64'h1, 1'b1, 4'(it), 64'h2);
    idle();
    chk_eq("collide_en0", 64'(en0), 64'd1);
    chk_eq("collide_val", val0,     64'h1);

    // Randomized traffic with alternating fill-heavy and drain-heavy phases.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      pct_alloc = ((cyc / 200) % 2 == 1) ? 85 : 45;
      pct_wb    = ((cyc / 200) % 2 == 1) ? 30 : 80;
      cand = {};
      foreach (rob[i]) if (!rob[i].done) cand.push_back(rob[i].tag);
      av = ($urandom_range(0, 99) < pct_alloc);
      iv = 1'b0; lv = 1'b0; it = 0; lt = 0;
      if (cand.size() > 0 && $urandom_range(0, 99) < pct_wb) begin
        iv = 1'b1; it = cand[$urandom_range(0, cand.size() - 1)];
      end else if ($urandom_range(0, 99) < 5) begin
        iv = 1'b1; it = $urandom_range(0, DEPTH - 1);
      end
      if (cand.size() > 0 && $urandom_range(0, 99) < pct_wb) begin
        lv = 1'b1; lt = cand[$urandom_range(0, cand.size() - 1)];
      end else if ($urandom_range(0, 99) < 5) begin
        lv = 1'b1; lt = $urandom_range(0, DEPTH - 1);
      end
      if (iv && lv && it == lt) lv = 1'b0;
      step(av, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 3) != 0),
           iv, 4'(it), {$urandom, $urandom}, lv, 4'(lt), {$urandom, $urandom});
    end
    drain();

    // Reset with five entries in flight, asserted between clock edges.
    for (int k = 0; k < 5; k++) alloc(6'(k + 1), 1'b1);
    wb_int(rob[0].tag, 64'hABCD);
    idle();
    alloc_valid = 1'b0; int_valid = 1'b0; ls_valid = 1'b0;
    #2 res = 1'b1;
    #1;
    model_reset();
    chk_eq("arst_count", 64'(count),       64'd0);
    chk_eq("arst_ready", 64'(alloc_ready), 64'd1);
    chk_eq("arst_tag",   64'(alloc_tag),   64'd0);
    chk_eq("arst_en0",   64'(en0),         64'd0);
    chk_eq("arst_out0",  val0 | 64'(sel0), 64'd0);
    @(negedge clk);
    res = 1'b0;
    step(1'b0, 6'd0, 1'b0, 1'b1, 4'd1, 64'h99, 1'b1, 4'd2, 64'h98);
    wb_int(0, 64'h97);
    alloc(6'd7, 1'b1);
    idle();
    idle();
    chk_eq("arst_stale_en0",   64'(en0),   64'd0);
    chk_eq("arst_stale_count", 64'(count), 64'd1);
    wb_int(0, 64'h4242);
    idle();
    chk_eq("arst_new_val0", val0, 64'h4242);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
